// File: rtl/pc_fetch_if.sv
// Instruction-memory request/grant/response bundle between the fetch sequencer (master) and imem (slave).
interface pc_fetch_if;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_GNT;
  logic        IMEM_RVALID;
  logic [31:0] IMEM_RDATA;

  modport master (
    output IMEM_REQ,
    output IMEM_ADDR,
    input  IMEM_GNT,
    input  IMEM_RVALID,
    input  IMEM_RDATA
  );

  modport slave (
    input  IMEM_REQ,
    input  IMEM_ADDR,
    output IMEM_GNT,
    output IMEM_RVALID,
    output IMEM_RDATA
  );
endinterface

// File: rtl/pc_fetch.sv
// OTTER PC register + fetch sequencer: 3 cycles reset-to-IR_VALID with zero-wait imem, stalls on GNT/RVALID, holds in READY until PC_WRITE.
// PC_FETCH_MISALIGN_TRAP_EN: misaligned PC_DIN traps to a sticky HALT (MISALIGN_ERR) instead of clearing the low bits.
module pc_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        PC_WRITE,
  input  logic [31:0] PC_DIN,
  pc_fetch_if.master  imem,
  output logic [31:0] PC,
  output logic [31:0] PC_four,
  output logic [31:0] IR,
  output logic        IR_VALID,
`ifdef PC_FETCH_MISALIGN_TRAP_EN
  output logic        MISALIGN_ERR,
`endif
  output logic        FETCH_BUSY
);

`ifdef PC_FETCH_MISALIGN_TRAP_EN
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_READY, S_HALT} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_READY} state_t;
`endif

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic        r_ir_valid;
  logic [31:0] w_pc_aligned;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
  logic        r_misalign;
  logic        w_misaligned;

  assign w_misaligned = (PC_DIN[1:0] != 2'b00);
`endif

  assign w_pc_aligned = PC_DIN & 32'hFFFF_FFFC;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_VECTOR;
      r_ir       <= NOP;
      r_ir_valid <= 1'b0;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
      r_misalign <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: r_state <= S_REQ;
        S_REQ: begin
          if (imem.IMEM_GNT) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (imem.IMEM_RVALID) begin
            r_ir       <= imem.IMEM_RDATA;
            r_ir_valid <= 1'b1;
            r_state    <= S_READY;
          end
        end
        S_READY: begin
          if (PC_WRITE) begin
            r_ir_valid <= 1'b0;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
            if (w_misaligned) begin
              r_misalign <= 1'b1;
              r_state    <= S_HALT;
            end else begin
              r_pc    <= w_pc_aligned;
              r_state <= S_REQ;
            end
`else
            r_pc    <= w_pc_aligned;
            r_state <= S_REQ;
`endif
          end
        end
`ifdef PC_FETCH_MISALIGN_TRAP_EN
        // Only RST leaves HALT.
        S_HALT: r_state <= S_HALT;
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign imem.IMEM_REQ  = (r_state == S_REQ);
  assign imem.IMEM_ADDR = r_pc;
  assign PC             = r_pc;
  assign PC_four        = r_pc + 32'd4;
  assign IR             = r_ir;
  assign IR_VALID       = r_ir_valid;
  assign FETCH_BUSY     = (r_state == S_IDLE) || (r_state == S_REQ) || (r_state == S_WAIT);
`ifdef PC_FETCH_MISALIGN_TRAP_EN
  assign MISALIGN_ERR   = r_misalign;
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: stimulus pushes expected (PC, IR) pairs, a monitor checks each IR_VALID rise.
module tb_pc_fetch;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        PC_WRITE = 1'b0;
  logic [31:0] PC_DIN = 32'h0;
  logic [31:0] PC, PC_four, IR;
  logic        IR_VALID, FETCH_BUSY;
`ifdef PC_FETCH_MISALIGN_TRAP_EN
  logic        MISALIGN_ERR;
`endif

  pc_fetch_if imem();

  logic        mem_en = 1'b1;
  logic        m_gnt = 1'b0, m_rv = 1'b0, s_gnt = 1'b0, s_rv = 1'b0;
  logic [31:0] m_rdata = 32'h0, s_rdata = 32'h0, m_addr = 32'h0;
  int          gnt_dly = 0, rv_dly = 0;
  int          phase, cnt;
  int          n_checks = 0, n_fail = 0;
  int          n;
  logic        prev_vld;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
  } exp_t;
  exp_t exp_q[$];
  exp_t e_mon;

  assign imem.IMEM_GNT    = mem_en ? m_gnt   : s_gnt;
  assign imem.IMEM_RVALID = mem_en ? m_rv    : s_rv;
  assign imem.IMEM_RDATA  = mem_en ? m_rdata : s_rdata;

  pc_fetch #(.RESET_VECTOR(32'h0000_0100)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .PC_WRITE   (PC_WRITE),
    .PC_DIN     (PC_DIN),
    .imem       (imem),
    .PC         (PC),
    .PC_four    (PC_four),
    .IR         (IR),
    .IR_VALID   (IR_VALID),
`ifdef PC_FETCH_MISALIGN_TRAP_EN
    .MISALIGN_ERR(MISALIGN_ERR),
`endif
    .FETCH_BUSY (FETCH_BUSY)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0100: mem_word = 32'h0050_0093;
      32'h0000_0200: mem_word = 32'h00a0_0113;
      32'h0000_0300: mem_word = 32'h01f0_0193;
      32'hFFFF_FFFC: mem_word = 32'h0000_006f;
      32'h0000_0000: mem_word = 32'h0000_0297;
      default:       mem_word = 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Memory model: GNT after gnt_dly REQ cycles, RVALID rv_dly cycles after the GNT edge.
  initial begin
    phase = 0;
    cnt   = 0;
    forever begin
      @(posedge CLK);
      #1;
      m_gnt = 1'b0;
      m_rv  = 1'b0;
      if (RST || !mem_en) begin
        phase = 0;
        cnt   = 0;
      end else if (phase == 0) begin
        if (imem.IMEM_REQ) begin
          if (cnt == gnt_dly) begin
            m_gnt  = 1'b1;
            m_addr = imem.IMEM_ADDR;
            phase  = 1;
            cnt    = 0;
          end else begin
            cnt++;
          end
        end
      end else begin
        if (cnt == rv_dly) begin
          m_rv    = 1'b1;
          m_rdata = mem_word(m_addr);
          phase   = 0;
          cnt     = 0;
        end else begin
          cnt++;
        end
      end
    end
  end

  initial begin
    prev_vld = 1'b0;
    forever begin
      @(negedge CLK);
      if (IR_VALID && !prev_vld) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_fetch: pc %h ir %h, no fetch expected", PC, IR);
        end else begin
          e_mon = exp_q.pop_front();
          check32("fetch_pc", PC, e_mon.pc);
          check32("fetch_ir", IR, e_mon.ir);
        end
      end
      prev_vld = IR_VALID;
    end
  end

  // Counts negedges until IR_VALID; checks IMEM_ADDR in REQ; optionally pulses PC_WRITE while busy.
  task automatic wait_valid(input bit pulse, input logic [31:0] addr, output int cycles);
    bit done;
    done   = 1'b0;
    cycles = 0;
    while (!done && cycles < 40) begin
      @(negedge CLK);
      cycles++;
      if (IR_VALID) begin
        PC_WRITE = 1'b0;
        done     = 1'b1;
      end else begin
        if (imem.IMEM_REQ) check32("imem_addr_stable", imem.IMEM_ADDR, addr);
        if (pulse) begin
          PC_WRITE = 1'b1;
          PC_DIN   = 32'h0000_0400;
        end
      end
    end
    PC_WRITE = 1'b0;
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL fetch_timeout: IR_VALID still %b after %0d cycles, required 1", IR_VALID, cycles);
    end
  endtask

  task automatic do_write(input logic [31:0] din);
    @(negedge CLK);
    PC_WRITE = 1'b1;
    PC_DIN   = din;
    @(posedge CLK);
    #1;
    PC_WRITE = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    check32("rst_pc", PC, 32'h0000_0100);
    check32("rst_pc_four", PC_four, 32'h0000_0104);
    check32("rst_ir", IR, 32'h0000_0013);
    check32("rst_ir_valid", {31'b0, IR_VALID}, 32'd0);
    check32("rst_imem_req", {31'b0, imem.IMEM_REQ}, 32'd0);
    check32("rst_fetch_busy", {31'b0, FETCH_BUSY}, 32'd1);

    RST = 1'b0;
    exp_q.push_back('{32'h0000_0100, 32'h0050_0093});
    wait_valid(1'b0, 32'h0000_0100, n);
    check32("first_fetch_cycles", n, 32'd3);
    check32("ready_not_busy", {31'b0, FETCH_BUSY}, 32'd0);

    do_write(32'h0000_0200);
    check32("write_pc", PC, 32'h0000_0200);
    check32("write_pc_four", PC_four, 32'h0000_0204);
    check32("write_ir_valid_low", {31'b0, IR_VALID}, 32'd0);
    exp_q.push_back('{32'h0000_0200, 32'h00a0_0113});
    wait_valid(1'b0, 32'h0000_0200, n);
    check32("write_fetch_cycles", n, 32'd3);

    gnt_dly = 3;
    rv_dly  = 2;
    do_write(32'h0000_0300);
    exp_q.push_back('{32'h0000_0300, 32'h01f0_0193});
    wait_valid(1'b1, 32'h0000_0300, n);
    check32("slow_fetch_cycles", n, 32'd8);
    check32("slow_pc_ignored_writes", PC, 32'h0000_0300);
    gnt_dly = 0;
    rv_dly  = 0;

    do_write(32'hFFFF_FFFC);
    exp_q.push_back('{32'hFFFF_FFFC, 32'h0000_006f});
    wait_valid(1'b0, 32'hFFFF_FFFC, n);
    check32("wrap_pc_four", PC_four, 32'h0000_0000);
    do_write(PC_four);
    exp_q.push_back('{32'h0000_0000, 32'h0000_0297});
    wait_valid(1'b0, 32'h0000_0000, n);

    do_write(32'h0000_0500);
    @(negedge CLK);
    check32("abort_in_req", {31'b0, imem.IMEM_REQ}, 32'd1);
    @(negedge CLK);
    check32("abort_in_wait", {31'b0, imem.IMEM_REQ}, 32'd0);
    RST    = 1'b1;
    mem_en = 1'b0;
    #1;
    check32("abort_pc", PC, 32'h0000_0100);
    check32("abort_ir", IR, 32'h0000_0013);
    check32("abort_ir_valid", {31'b0, IR_VALID}, 32'd0);
    check32("abort_busy", {31'b0, FETCH_BUSY}, 32'd1);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    check32("release_idle_req", {31'b0, imem.IMEM_REQ}, 32'd0);
    @(negedge CLK);
    check32("release_req", {31'b0, imem.IMEM_REQ}, 32'd1);
    s_rv    = 1'b1;
    s_rdata = 32'hBAD0_0BAD;
    @(negedge CLK);
    s_rv = 1'b0;
    check32("stale_ir", IR, 32'h0000_0013);
    check32("stale_ir_valid", {31'b0, IR_VALID}, 32'd0);
    check32("stale_still_req", {31'b0, imem.IMEM_REQ}, 32'd1);
    exp_q.push_back('{32'h0000_0100, 32'h0050_0093});
    mem_en = 1'b1;
    wait_valid(1'b0, 32'h0000_0100, n);
    check32("refetch_cycles", n, 32'd3);

    do_write(32'h0000_0203);
`ifdef PC_FETCH_MISALIGN_TRAP_EN
    check32("trap_pc_held", PC, 32'h0000_0100);
    check32("trap_err", {31'b0, MISALIGN_ERR}, 32'd1);
    check32("trap_ir_valid", {31'b0, IR_VALID}, 32'd0);
    check32("trap_req", {31'b0, imem.IMEM_REQ}, 32'd0);
    check32("trap_busy", {31'b0, FETCH_BUSY}, 32'd0);
    repeat (4) @(negedge CLK);
    check32("halt_req", {31'b0, imem.IMEM_REQ}, 32'd0);
    check32("halt_err_sticky", {31'b0, MISALIGN_ERR}, 32'd1);
    RST = 1'b1;
    #1;
    check32("halt_rst_err", {31'b0, MISALIGN_ERR}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
`else
    check32("misalign_pc_cleared", PC, 32'h0000_0200);
    exp_q.push_back('{32'h0000_0200, 32'h00a0_0113});
    wait_valid(1'b0, 32'h0000_0200, n);
    check32("misalign_fetch_cycles", n, 32'd3);
`endif

    repeat (2) @(negedge CLK);
    check32("scoreboard_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
